t1_run_sequencer: RTL and testbench
===================================

Name: t1_run_sequencer

Overview:
Synthesizable run controller for the T1 emulation harness.
- Sequences DUT reset release and counts run cycles.
- Polls the cosim watchdog through a req/ack handshake and opens a trace window between configured start and end cycles.
- Raises a terminal done or fault indication.
- Sits between the clock/reset source and the DUT; the DPI or host side answers watchdog polls.

Parameters:
RESET_HOLD, 2, cycles dut_reset stays high after reset deasserts (≥1)
CYCLE_W, 64, width of cycle counter and dump bounds
POLL_PERIOD, 1, RUN cycles between watchdog polls (≥1)
POLL_TIMEOUT, 1024, max cycles waiting for wd_ack (used only with optional feature)

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high
dump_start  in  CYCLE_W  first traced cycle; 0 = trace from first RUN cycle
dump_end  in  CYCLE_W  cycle at which run faults; 0 = disabled
dut_reset  out  1  reset to DUT
wd_req  out  1  watchdog poll request
wd_ack  in  1  watchdog response valid
wd_status  in  8  watchdog result: 0 continue, 255 finish, other error
trace_en  out  1  wave dump window active
cycle  out  CYCLE_W  completed run cycles
done  out  1  successful finish, sticky
fault  out  1  error finish, sticky
fault_code  out  2  1 watchdog error, 2 dump_end reached, 3 poll timeout

Behaviour:
- Clock and reset: single clock; reset is synchronous, active-high; all state updates on rising clock.
- Reset values: dut_reset=1, wd_req=0, trace_en=0, cycle=0, done=0, fault=0, fault_code=0, state=INIT.
- Reset mid-operation (any state, including POLL with req outstanding): next edge returns to INIT with reset values. wd_ack arriving during or after reset is ignored.
- dump_start and dump_end are quasi-static. They are sampled into registers on the last INIT cycle and ignored afterwards.
- INIT:
  - Counts RESET_HOLD cycles after reset low, then enters RUN.
  - dut_reset drops on the same edge RUN is entered.
- RUN:
  - cycle increments by 1 every edge in RUN or POLL; saturates at all-ones, no wrap.
  - Poll-interval counter reaches POLL_PERIOD → enter POLL and assert wd_req on that edge.
- POLL:
  - wd_req stays high until the cycle wd_ack=1 is sampled. wd_ack while wd_req=0 is ignored.
  - On ack:
    - status 0 → RUN; wd_req drops; interval counter restarts.
    - status 255 → DONE.
    - other status → FAULT, fault_code=1.
- dump_end check: when dump_end≠0 and cycle==dump_end in RUN/POLL → FAULT, fault_code=2.
- Simultaneous events: a wd_ack result in the same cycle as the dump_end hit takes priority (255 → DONE).
- DONE / FAULT:
  - Terminal until reset. done or fault asserted on entry; wd_req=0, trace_en=0.
  - cycle freezes; dut_reset stays 0.
- trace_en:
  - Registered; high in RUN/POLL when cycle ≥ dump_start.
  - With dump_start=0, high from the first RUN cycle.
- Latency: ack→state change is 1 edge. Poll issue occurs POLL_PERIOD RUN cycles after entering RUN or after the previous ack.

Optional Feature:
T1_SEQ_POLL_TIMEOUT_EN
- Defined: a counter runs while in POLL. If POLL_TIMEOUT cycles pass with no wd_ack → FAULT, fault_code=3, wd_req drops. An ack on the timeout cycle itself wins.
- Undefined: no counter; POLL waits indefinitely; fault_code 3 is never produced.

Test Plan:
1. Reset release: RESET_HOLD=2, reset high 3 cycles then low → dut_reset low exactly 2 edges after reset falls; cycle=0 on the first RUN cycle, 1 on the next.
2. Normal finish: POLL_PERIOD=1, ack status 0 on first 9 polls, 255 on 10th → done=1, fault=0, cycle frozen, wd_req=0 thereafter.
3. Watchdog error: ack status 7 on 3rd poll → fault=1, fault_code=1, trace_en=0 next cycle.
4. Trace window: dump_start=5, dump_end=20, always ack 0 → trace_en first high when cycle=5; fault_code=2 when cycle=20. Repeat with ack=255 on the cycle==20 edge → done=1, fault=0.
5. Mid-poll reset: wd_req high, no ack, assert reset 1 cycle → wd_req=0, dut_reset=1, cycle=0 next edge. A late wd_ack ignored; normal sequence resumes.
6. With T1_SEQ_POLL_TIMEOUT_EN, POLL_TIMEOUT=8, never ack → fault_code=3 after 8 POLL cycles. Without the macro, wd_req still high after 100 cycles.

Source files
------------

// File: rtl/t1_run_sequencer.sv
// Run controller for the T1 emulation harness: DUT reset release, cycle count, watchdog polling,
// trace window and terminal done/fault. Define T1_SEQ_POLL_TIMEOUT_EN to bound the wait for wd_ack.
module t1_run_sequencer #(
    parameter int RESET_HOLD   = 2,
    parameter int CYCLE_W      = 64,
    parameter int POLL_PERIOD  = 1,
    parameter int POLL_TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CYCLE_W-1:0] dump_start,
    input  logic [CYCLE_W-1:0] dump_end,
    output logic               dut_reset,
    output logic               wd_req,
    input  logic               wd_ack,
    input  logic [7:0]         wd_status,
    output logic               trace_en,
    output logic [CYCLE_W-1:0] cycle,
    output logic               done,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [2:0]         state_dbg
);

    if (RESET_HOLD < 1 || POLL_PERIOD < 1 || POLL_TIMEOUT < 1) begin : g_bad_param
        $error("t1_run_sequencer: RESET_HOLD, POLL_PERIOD and POLL_TIMEOUT must be >= 1");
    end

    localparam int HW = $clog2(RESET_HOLD + 1);
    localparam int PW = $clog2(POLL_PERIOD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {S_INIT, S_RUN, S_POLL, S_DONE, S_FAULT} state_t;

    state_t             state, state_nxt;
    logic [HW-1:0]      hold_cnt, hold_nxt;
    logic [PW-1:0]      poll_cnt, poll_nxt;
    logic [CYCLE_W-1:0] start_r, start_nxt, end_r, end_nxt, cycle_nxt;
    logic [1:0]         code_nxt;
    logic               end_hit, live, live_nxt;
`ifdef T1_SEQ_POLL_TIMEOUT_EN
    localparam int TW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(POLL_TIMEOUT - 1);
    logic [TW-1:0]      wait_cnt, wait_nxt;
`endif

    assign state_dbg = state;
    assign live      = (state == S_RUN) || (state == S_POLL);
    assign live_nxt  = (state_nxt == S_RUN) || (state_nxt == S_POLL);
    assign end_hit   = (end_r != '0) && (cycle == end_r);

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        poll_nxt  = poll_cnt;
        start_nxt = start_r;
        end_nxt   = end_r;
        code_nxt  = fault_code;
        cycle_nxt = cycle;
`ifdef T1_SEQ_POLL_TIMEOUT_EN
        wait_nxt  = wait_cnt;
`endif
        case (state)
            S_INIT: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = S_RUN;
                    poll_nxt  = '0;
                    start_nxt = dump_start;
                    end_nxt   = dump_end;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (end_hit) begin
                    state_nxt = S_FAULT;
                    code_nxt  = 2'd2;
                end else if (poll_cnt == POLL_LAST) begin
                    state_nxt = S_POLL;
                    poll_nxt  = '0;
`ifdef T1_SEQ_POLL_TIMEOUT_EN
                    wait_nxt  = '0;
`endif
                end else begin
                    poll_nxt = poll_cnt + 1'b1;
                end
            end
            S_POLL: begin
                // A terminal watchdog answer beats the dump_end hit; a "continue" answer does not.
                if (wd_ack && wd_status == 8'd255) begin
                    state_nxt = S_DONE;
                end else if (wd_ack && wd_status != 8'd0) begin
                    state_nxt = S_FAULT;
                    code_nxt  = 2'd1;
                end else if (end_hit) begin
                    state_nxt = S_FAULT;
                    code_nxt  = 2'd2;
                end else if (wd_ack) begin
                    state_nxt = S_RUN;
                    poll_nxt  = '0;
                end
`ifdef T1_SEQ_POLL_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    state_nxt = S_FAULT;
                    code_nxt  = 2'd3;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
`endif
            end
            default: ;
        endcase
        // The edge that terminates the run does not count, so cycle shows the cycle it stopped on.
        if (live && live_nxt && cycle != '1) begin
            cycle_nxt = cycle + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_INIT;
            hold_cnt   <= '0;
            poll_cnt   <= '0;
            start_r    <= '0;
            end_r      <= '0;
            cycle      <= '0;
            dut_reset  <= 1'b1;
            wd_req     <= 1'b0;
            trace_en   <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'd0;
`ifdef T1_SEQ_POLL_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            poll_cnt   <= poll_nxt;
            start_r    <= start_nxt;
            end_r      <= end_nxt;
            cycle      <= cycle_nxt;
            dut_reset  <= (state_nxt == S_INIT);
            wd_req     <= (state_nxt == S_POLL);
            trace_en   <= live_nxt && (cycle_nxt >= start_nxt);
            done       <= (state_nxt == S_DONE);
            fault      <= (state_nxt == S_FAULT);
            fault_code <= code_nxt;
`ifdef T1_SEQ_POLL_TIMEOUT_EN
            wait_cnt   <= wait_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_t1_run_sequencer.sv
// Bench for t1_run_sequencer: abstract run model checked every cycle plus hand-computed milestones.
// Build with or without T1_SEQ_POLL_TIMEOUT_EN.
module tb_t1_run_sequencer;

    localparam int CW      = 8;
    localparam int HOLD    = 2;
    localparam int PERIOD  = 1;
    localparam int POLL_TO = 8;
    localparam longint CMAX = (longint'(1) << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] dump_start = '0;
    logic [CW-1:0] dump_end = '0;
    logic          dut_reset, wd_req, trace_en, done, fault;
    logic          wd_ack = 1'b0;
    logic [7:0]    wd_status = 8'd0;
    logic [CW-1:0] cycle;
    logic [1:0]    fault_code;
    logic [2:0]    state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    t1_run_sequencer #(
        .RESET_HOLD(HOLD), .CYCLE_W(CW), .POLL_PERIOD(PERIOD), .POLL_TIMEOUT(POLL_TO)
    ) dut (
        .clock(clock), .reset(reset), .dump_start(dump_start), .dump_end(dump_end),
        .dut_reset(dut_reset), .wd_req(wd_req), .wd_ack(wd_ack), .wd_status(wd_status),
        .trace_en(trace_en), .cycle(cycle), .done(done), .fault(fault),
        .fault_code(fault_code), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Watchdog responder: answers each outstanding poll with the next queued status.
    bit         resp_on = 1'b0;
    bit         stray = 1'b0;
    int         skip_n = 0;
    logic [7:0] dflt_status = 8'd0;
    logic [7:0] st_q[$];

    initial forever begin
        @(negedge clock);
        if (stray) begin
            wd_ack = 1'b1;
            wd_status = 8'd255;
        end else if (resp_on && !reset && wd_req) begin
            if (skip_n > 0) begin
                skip_n--;
                wd_ack = 1'b0;
            end else begin
                wd_ack = 1'b1;
                wd_status = (st_q.size() > 0) ? st_q.pop_front() : dflt_status;
            end
        end else begin
            wd_ack = 1'b0;
            wd_status = 8'd0;
        end
    end

    // Run model in terms of phases: holding reset, running (possibly awaiting an answer), finished.
    bit     m_valid = 0, m_init = 0, m_run = 0, m_wait = 0, m_done = 0, m_fault = 0, m_term = 0;
    int     m_left = 0, m_since = 0, m_waited = 0, m_code = 0;
    longint m_cycle = 0, m_start = 0, m_end = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_valid = 1; m_init = 1; m_left = HOLD; m_run = 0; m_wait = 0;
            m_done = 0; m_fault = 0; m_code = 0; m_cycle = 0; m_start = 0; m_end = 0;
        end else if (m_valid && m_init) begin
            m_left--;
            if (m_left == 0) begin
                m_init = 0; m_run = 1; m_since = 0;
                m_start = longint'(dump_start); m_end = longint'(dump_end);
            end
        end else if (m_valid && m_run) begin
            m_term = 1;
            if (m_wait && wd_ack && wd_status == 8'd255) m_done = 1;
            else if (m_wait && wd_ack && wd_status != 8'd0) begin m_fault = 1; m_code = 1; end
            else if (m_end != 0 && m_cycle == m_end) begin m_fault = 1; m_code = 2; end
            else begin
                m_term = 0;
                if (m_wait) begin
                    if (wd_ack) begin m_wait = 0; m_since = 0; end
                    else begin
                        m_waited++;
`ifdef T1_SEQ_POLL_TIMEOUT_EN
                        if (m_waited == POLL_TO) begin m_fault = 1; m_code = 3; m_term = 1; end
`endif
                    end
                end else begin
                    m_since++;
                    if (m_since == PERIOD) begin m_wait = 1; m_waited = 0; end
                end
            end
            if (m_term) begin m_run = 0; m_wait = 0; end
            else if (m_cycle < CMAX) m_cycle++;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("dut_reset", dut_reset, m_init);
            check("wd_req", wd_req, m_wait);
            check("trace_en", trace_en, m_run && m_cycle >= m_start);
            check("cycle", cycle, m_cycle);
            check("done", done, m_done);
            check("fault", fault, m_fault);
            check("fault_code", fault_code, m_code);
        end
    end

    task automatic enter_reset();
        reset = 1'b1;
        step(1);
    endtask

    // Two more reset edges, then RESET_HOLD edges of INIT; returns in the first RUN cycle.
    task automatic release_run();
        step(2);
        reset = 1'b0;
        step(HOLD);
    endtask

    task automatic wait_term(input string name, input int budget);
        for (int i = 0; i < budget && !(done || fault); i++) step(1);
        check(name, done || fault, 1);
    endtask

    initial begin
        // 1: reset values and release timing
        resp_on = 1;
        step(1);
        check("rst_dut_reset", dut_reset, 1);
        check("rst_cycle", cycle, 0);
        check("rst_wd_req", wd_req, 0);
        check("rst_done", done, 0);
        step(2);
        reset = 1'b0;
        step(1);
        check("hold_edge1_dut_reset", dut_reset, 1);
        step(1);
        check("hold_edge2_dut_reset", dut_reset, 0);
        check("first_run_cycle", cycle, 0);
        check("first_run_trace", trace_en, 1);
        step(1);
        check("second_run_cycle", cycle, 1);
        check("first_poll_req", wd_req, 1);

        // 2: nine continues then finish on the 10th poll (acked with cycle 19)
        enter_reset();
        for (int i = 0; i < 9; i++) st_q.push_back(8'd0);
        st_q.push_back(8'd255);
        release_run();
        wait_term("finish_reached", 60);
        check("finish_done", done, 1);
        check("finish_fault", fault, 0);
        check("finish_cycle", cycle, 19);
        step(5);
        check("finish_cycle_frozen", cycle, 19);
        check("finish_req_low", wd_req, 0);

        // 3: error status on the 3rd poll (acked with cycle 5)
        enter_reset();
        st_q = '{8'd0, 8'd0, 8'd7};
        release_run();
        wait_term("wderr_reached", 30);
        check("wderr_fault", fault, 1);
        check("wderr_code", fault_code, 1);
        check("wderr_cycle", cycle, 5);
        check("wderr_trace", trace_en, 0);

        // 4a: trace window opens at cycle 5, dump_end faults at cycle 20
        enter_reset();
        st_q.delete();
        dump_start = 8'd5;
        dump_end = 8'd20;
        release_run();
        for (int i = 0; i < 30 && !trace_en; i++) step(1);
        check("trace_open_cycle", cycle, 5);
        wait_term("dumpend_reached", 40);
        check("dumpend_code", fault_code, 2);
        check("dumpend_cycle", cycle, 20);
        check("dumpend_done", done, 0);

        // 4b: one delayed ack puts polls on even cycles; the 10th poll (cycle 20) finishes
        enter_reset();
        skip_n = 1;
        for (int i = 0; i < 9; i++) st_q.push_back(8'd0);
        st_q.push_back(8'd255);
        release_run();
        wait_term("coinc_reached", 40);
        check("coinc_done", done, 1);
        check("coinc_fault", fault, 0);
        check("coinc_cycle", cycle, 20);

        // 5: reset while a poll is outstanding; acks during and after reset are ignored
        enter_reset();
        dump_start = '0;
        dump_end = '0;
        resp_on = 0;
        release_run();
        step(3);
        check("midpoll_req", wd_req, 1);
        reset = 1'b1;
        stray = 1;
        step(1);
        check("midpoll_req_drop", wd_req, 0);
        check("midpoll_dut_reset", dut_reset, 1);
        check("midpoll_cycle", cycle, 0);
        reset = 1'b0;
        step(HOLD);
        check("stray_dut_reset", dut_reset, 0);
        check("stray_done", done, 0);
        step(1);
        stray = 0;
        resp_on = 1;
        check("stray_cycle", cycle, 1);
        check("stray_poll_req", wd_req, 1);
        step(10);
        check("resume_cycle", cycle, 11);
        check("resume_no_fault", fault, 0);

        // 6: watchdog never answers
        enter_reset();
        resp_on = 0;
        release_run();
`ifdef T1_SEQ_POLL_TIMEOUT_EN
        wait_term("timeout_reached", 30);
        check("timeout_code", fault_code, 3);
        check("timeout_cycle", cycle, 8);
        check("timeout_req_low", wd_req, 0);
`else
        step(100);
        check("no_timeout_req", wd_req, 1);
        check("no_timeout_fault", fault, 0);
`endif

        // Saturation: cycle stops at all-ones
        enter_reset();
        resp_on = 1;
        release_run();
        step(300);
        check("sat_cycle", cycle, CMAX);
        check("sat_no_fault", fault, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
